// File: rtl/perceptron_mac.sv
// rtl/perceptron_mac.sv - perceptron multiply-accumulate stage with step activation
// Define PERCEPTRON_BIAS_EN to add a bias read at address N (input treated as +1).
module perceptron_mac #(
  parameter int                      N         = 8,
  parameter int                      ADDR_W    = 8,
  parameter int                      ACC_W     = 20,
  parameter logic signed [ACC_W-1:0] THRESHOLD = '0
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              start,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        in_data,
  input  logic [7:0]        w_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [ACC_W-1:0]  acc_out
);

`ifdef PERCEPTRON_BIAS_EN
  localparam int NR = N + 1;
`else
  localparam int NR = N;
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NR - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic               rd_en_d;
  logic signed [15:0] prod;
  logic [ACC_W-1:0]   term;
  logic [ACC_W-1:0]   acc_sum;
`ifdef PERCEPTRON_BIAS_EN
  logic               bias_d;
`endif

  // Bank data lags rd_en by one cycle, so rd_en_d marks a valid in_data/w_data pair.
  always_comb begin
    prod = $signed(in_data) * $signed(w_data);
    term = '0;
    if (rd_en_d) begin
`ifdef PERCEPTRON_BIAS_EN
      if (bias_d)
        term = {{(ACC_W-8){w_data[7]}}, w_data};
      else
        term = {{(ACC_W-16){prod[15]}}, prod};
`else
      term = {{(ACC_W-16){prod[15]}}, prod};
`endif
    end
    acc_sum = acc + term;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      rd_en_d   <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      acc_out   <= '0;
`ifdef PERCEPTRON_BIAS_EN
      bias_d    <= 1'b0;
`endif
    end else begin
      rd_en_d <= rd_en;
`ifdef PERCEPTRON_BIAS_EN
      bias_d  <= rd_en && (rd_addr == ADDR_W'(N));
`endif
      case (state)
        IDLE: begin
          if (start) begin
            acc     <= '0;
            rd_addr <= '0;
            rd_en   <= 1'b1;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          acc <= acc_sum;
          if (rd_addr == LAST_ADDR) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // The last product lands this cycle, so the result is taken from acc_sum.
          acc       <= acc_sum;
          acc_out   <= acc_sum;
          out_data  <= ($signed(acc_sum) >= THRESHOLD) ? 8'h01 : 8'h00;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_mac.sv
// tb/tb_perceptron_mac.sv - directed scoreboard bench for perceptron_mac
module tb_perceptron_mac;
  localparam int N      = 8;
  localparam int ADDR_W = 8;
  localparam int ACC_W  = 20;
  localparam int THR    = 36;
`ifdef PERCEPTRON_BIAS_EN
  localparam int NR = N + 1;
`else
  localparam int NR = N;
`endif

  logic              clk = 1'b0;
  logic              nRst;
  logic              start;
  logic              busy;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        in_data;
  logic [7:0]        w_data;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic [ACC_W-1:0]  acc_out;

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic [7:0]       data;
  } exp_t;

  exp_t              exp_q[$];
  logic signed [7:0] in_mem[256];
  logic signed [7:0] w_mem[256];
  int                read_count = 0;
  int                over_count = 0;
  int                tests = 0;
  int                fails = 0;

  perceptron_mac #(
    .N(N), .ADDR_W(ADDR_W), .ACC_W(ACC_W), .THRESHOLD(ACC_W'(THR))
  ) dut (
    .clk(clk), .nRst(nRst), .start(start), .busy(busy), .rd_en(rd_en),
    .rd_addr(rd_addr), .in_data(in_data), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .acc_out(acc_out)
  );

  always #5 clk = ~clk;

  // Register banks: synchronous read, data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      in_data    <= in_mem[rd_addr];
      w_data     <= w_mem[rd_addr];
      read_count <= read_count + 1;
      if (int'(rd_addr) >= NR) over_count <= over_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 256; k++) begin
      in_mem[k] = 8'sd0;
      w_mem[k]  = 8'sd0;
    end
  endtask

  task automatic push_expected();
    int   s;
    exp_t e;
    s = 0;
    for (int k = 0; k < N; k++) s += int'(in_mem[k]) * int'(w_mem[k]);
`ifdef PERCEPTRON_BIAS_EN
    s += int'(w_mem[N]);
`endif
    e.acc  = ACC_W'(s);
    e.data = (s >= THR) ? 8'h01 : 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic run_eval(input string tag, input int hold);
    int               rc0, oc0, n;
    bit               stable;
    logic [ACC_W-1:0] a0;
    logic [7:0]       d0;
    exp_t             e;
    push_expected();
    rc0 = read_count;
    oc0 = over_count;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(NR + 1));
    check({tag, " reads"}, 32'(read_count - rc0), 32'(NR));
    check({tag, " addr_range"}, 32'(over_count - oc0), 32'd0);
    check({tag, " last_addr"}, 32'(rd_addr), 32'(NR - 1));
    a0 = acc_out;
    d0 = out_data;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      start = (h % 7 == 3);
      @(posedge clk); #1;
      start = 1'b0;
      if (!(out_valid === 1'b1 && busy === 1'b1 && acc_out === a0 && out_data === d0))
        stable = 1'b0;
    end
    if (hold > 0) check({tag, " hold_stable"}, 32'(stable), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, " busy_drop"}, 32'(busy), 32'd0);
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, " acc_out"}, 32'(a0), 32'(e.acc));
      check({tag, " out_data"}, 32'(d0), 32'(e.data));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    nRst = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    clear_mem();
    #12;
    check("rst busy", 32'(busy), 32'd0);
    check("rst rd_en", 32'(rd_en), 32'd0);
    check("rst rd_addr", 32'(rd_addr), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    check("rst acc_out", 32'(acc_out), 32'd0);
    @(posedge clk); #1;
    nRst = 1'b1;
    @(posedge clk); #1;

    // in = 1..8, w = 1 -> 36, exactly at threshold
    for (int k = 0; k < N; k++) begin
      in_mem[k] = 8'(k + 1);
      w_mem[k]  = 8'sd1;
    end
    run_eval("sum36", 0);

    // Asynchronous reset in the middle of RUN
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    nRst = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst rd_en", 32'(rd_en), 32'd0);
    check("midrst rd_addr", 32'(rd_addr), 32'd0);
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst out_data", 32'(out_data), 32'd0);
    check("midrst acc_out", 32'(acc_out), 32'd0);
    @(posedge clk); #1;
    nRst = 1'b1;
    @(posedge clk); #1;
    run_eval("after_rst", 0);

    // Most negative sum, with backpressure and ignored start pulses
    for (int k = 0; k < N; k++) begin
      in_mem[k] = -8'sd128;
      w_mem[k]  = 8'sd127;
    end
    run_eval("neg_max", 50);

    // One below threshold -> 35
    for (int k = 0; k < N; k++) begin
      in_mem[k] = 8'(k + 1);
      w_mem[k]  = 8'sd1;
    end
    in_mem[7] = 8'sd7;
    run_eval("sum35", 3);

    // Bias word at address N
    clear_mem();
    w_mem[N] = -8'sd5;
    run_eval("bias", 0);

    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 256; k++) begin
        in_mem[k] = 8'($urandom_range(0, 255));
        w_mem[k]  = 8'($urandom_range(0, 255));
      end
      run_eval($sformatf("rand%0d", r), r * 5);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
